// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the TinyCPU 8-bit datapath.
// 1-byte instructions take 3 cycles, 2-byte (LDI/JMP/JZ) take 4; no backpressure, start ignored while busy.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       busy,
    output logic       halted,
    output logic [7:0] acc_dbg
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPFETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t          state_q;
    logic [7:0]      pc_q;
    logic [7:0]      ir_q;
    logic [7:0]      acc_q;
    logic [3:0][7:0] regs_q;
    logic            z_q;
    logic            busy_q;
    logic            halted_q;

    logic [7:0]      pc_inc;
    logic            unused_ir_bit;

    // LDI, JMP and JZ carry an immediate byte after the opcode
    function automatic logic is_two_byte(input logic [7:0] op);
        return (op[7:6] == 2'b01) || ((op[7:6] == 2'b11) && !op[5]);
    endfunction

    assign pc_inc        = pc_q + 8'd1;
    assign unused_ir_bit = ir_q[2];

    assign imem_addr  = pc_q;
    assign alu_opcode = ir_q[5:3];
    assign alu_a      = acc_q;
    assign alu_b      = regs_q[ir_q[1:0]];
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign acc_dbg    = acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            acc_q    <= 8'h00;
            regs_q   <= '0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc_q     <= RESET_PC;
                        state_q  <= S_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q    <= imem_data;
                    pc_q    <= pc_inc;
                    state_q <= is_two_byte(imem_data) ? S_OPFETCH : S_EXEC;
                end
                S_OPFETCH: state_q <= S_EXEC;
                S_EXEC: begin
                    // imem_data holds the immediate here for two-byte instructions
                    state_q <= S_FETCH;
                    case (ir_q[7:6])
                        2'b00: begin
                            acc_q <= alu_result;
                            z_q   <= alu_zero;
                        end
                        2'b01: begin
                            acc_q <= imem_data;
                            z_q   <= (imem_data == 8'h00);
                            pc_q  <= pc_inc;
                        end
                        2'b10: regs_q[ir_q[1:0]] <= acc_q;
                        2'b11: begin
                            case (ir_q[5:4])
                                2'b00: pc_q <= imem_data;
                                2'b01: pc_q <= z_q ? imem_data : pc_inc;
                                2'b10: begin
                                end
                                2'b11: begin
                                    state_q  <= S_HALTED;
                                    busy_q   <= 1'b0;
                                    halted_q <= 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: instruction-level reference model of TinyCPU driving expected
// per-cycle outputs, plus directed programs with hand-computed literal expectations.
module tb_control_unit;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       busy;
    logic       halted;
    logic [7:0] acc_dbg;

    int vectors;
    int miscompares;

    logic [7:0] rom [256];

    control_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .halted     (halted),
        .acc_dbg    (acc_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction ROM
    always @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = b;
            default: r = a << 1;
        endcase
        return r;
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_zero   = (alu_result == 8'h00);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] addr;
        logic       is_alu;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } rec_t;

    rec_t       q[$];
    logic [7:0] m_pc, m_acc;
    logic       m_z, m_run, m_halted;
    logic [7:0] m_r [4];
    logic [7:0] n_pc, n_acc;
    logic       n_z, n_halt;
    logic [7:0] n_r [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one record per cycle of the instruction at m_pc; effects land when the queue drains
    task automatic build();
        logic [7:0] b, p1, imm;
        rec_t       r;
        b   = rom[m_pc];
        p1  = m_pc + 8'd1;
        imm = rom[p1];
        n_acc = m_acc; n_z = m_z; n_r = m_r; n_halt = 1'b0; n_pc = p1;
        r = '0;
        r.addr = m_pc;
        q.push_back(r);
        q.push_back(r);
        if (b[7:6] == 2'b01 || (b[7:6] == 2'b11 && !b[5])) begin
            r.addr = p1;
            q.push_back(r);
        end
        r.addr   = p1;
        r.is_alu = (b[7:6] == 2'b00);
        r.op     = b[5:3];
        r.a      = m_acc;
        r.b      = m_r[b[1:0]];
        q.push_back(r);
        case (b[7:6])
            2'b00: begin
                n_acc = alu_f(b[5:3], m_acc, m_r[b[1:0]]);
                n_z   = (n_acc == 8'h00);
            end
            2'b01: begin
                n_acc = imm;
                n_z   = (imm == 8'h00);
                n_pc  = p1 + 8'd1;
            end
            2'b10: n_r[b[1:0]] = m_acc;
            default: begin
                case (b[5:4])
                    2'b00: n_pc = imm;
                    2'b01: n_pc = m_z ? imm : p1 + 8'd1;
                    2'b10: n_pc = p1;
                    default: n_halt = 1'b1;
                endcase
            end
        endcase
    endtask

    task automatic model_edge(input bit r, input bit s);
        if (!r) begin
            m_pc = RESET_PC; m_acc = 8'h00; m_z = 1'b0;
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
            m_run = 1'b0; m_halted = 1'b0;
            q.delete();
        end else begin
            if (q.size() != 0) begin
                q.delete(0);
                if (q.size() == 0) begin
                    m_pc = n_pc; m_acc = n_acc; m_z = n_z; m_r = n_r;
                    if (n_halt) begin
                        m_run = 1'b0;
                        m_halted = 1'b1;
                    end
                end
            end else if (s) begin
                m_pc = RESET_PC;
                m_run = 1'b1;
                m_halted = 1'b0;
            end
            if (m_run && q.size() == 0) build();
        end
    endtask

    task automatic compare();
        if (q.size() != 0) begin
            chk("imem_addr", 32'(imem_addr), 32'(q[0].addr));
            chk("busy", 32'(busy), 32'd1);
            chk("halted", 32'(halted), 32'd0);
            if (q[0].is_alu) begin
                chk("alu_opcode", 32'(alu_opcode), 32'(q[0].op));
                chk("alu_a", 32'(alu_a), 32'(q[0].a));
                chk("alu_b", 32'(alu_b), 32'(q[0].b));
            end
        end else begin
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("busy", 32'(busy), 32'd0);
            chk("halted", 32'(halted), 32'(m_halted));
        end
        chk("acc_dbg", 32'(acc_dbg), 32'(m_acc));
    endtask

    // Drive inputs for the next edge, advance the model across it, then check
    task automatic cycle(input bit r, input bit s);
        rst_n = r;
        start = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        compare();
    endtask

    task automatic rom_fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        imem_data = 8'h00;
        rom_fill(8'hF0);

        // Reset with start held high
        cycle(0, 1);
        cycle(0, 1);
        chk("rst_imem_addr", 32'(imem_addr), 32'h00);
        chk("rst_acc", 32'(acc_dbg), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);

        // LDI 10; MOV R1; LDI 20; ADD R1; HALT
        rom[0] = 8'h40; rom[1] = 8'd10; rom[2] = 8'h81; rom[3] = 8'h40;
        rom[4] = 8'd20; rom[5] = 8'h01; rom[6] = 8'hF0;
        cycle(1, 1);
        n = 1;
        chk("t1_busy_rise", 32'(busy), 32'd1);
        while (!halted && n < 60) begin
            cycle(1, 0);
            n++;
            if (n == 14) begin
                chk("t1_add_a", 32'(alu_a), 32'd20);
                chk("t1_r1_via_alu_b", 32'(alu_b), 32'd10);
            end
        end
        chk("t1_halt_cycle", 32'(n), 32'd18);
        chk("t1_acc", 32'(acc_dbg), 32'd30);
        chk("t1_busy_fall", 32'(busy), 32'd0);

        // LDI 5; MOV R0; SUB R0; JZ 0x20 (taken); restart from HALTED keeps acc
        rom_fill(8'hF0);
        rom[0] = 8'h40; rom[1] = 8'd5; rom[2] = 8'h80; rom[3] = 8'h08;
        rom[4] = 8'hD0; rom[5] = 8'h20;
        cycle(1, 1);
        n = 1;
        chk("t2_restart_acc", 32'(acc_dbg), 32'd30);
        chk("t2_restart_pc", 32'(imem_addr), 32'h00);
        while (!halted && n < 60) begin
            cycle(1, 0);
            n++;
            if (n == 11) chk("t2_sub_zero", 32'(acc_dbg), 32'd0);
            if (n == 15) chk("t2_jz_taken", 32'(imem_addr), 32'h20);
        end
        chk("t2_halt_cycle", 32'(n), 32'd18);

        // LDI 6; MOV R0; LDI 7; SUB R0 -> 1; JZ not taken
        rom_fill(8'hF0);
        rom[0] = 8'h40; rom[1] = 8'd6; rom[2] = 8'h80; rom[3] = 8'h40;
        rom[4] = 8'd7; rom[5] = 8'h08; rom[6] = 8'hD0; rom[7] = 8'h20;
        cycle(1, 1);
        n = 1;
        while (!halted && n < 60) begin
            cycle(1, 0);
            n++;
            if (n == 15) chk("t3_sub_one", 32'(acc_dbg), 32'd1);
            if (n == 19) chk("t3_jz_not_taken", 32'(imem_addr), 32'h08);
        end
        chk("t3_halt_cycle", 32'(n), 32'd22);

        // JMP 0xFF; NOP at 0xFF wraps pc to 0x00
        rom_fill(8'hF0);
        rom[0] = 8'hC0; rom[1] = 8'hFF; rom[255] = 8'hE0;
        cycle(1, 1);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0);
            n++;
            if (n == 5) chk("t4_jmp_ff", 32'(imem_addr), 32'hFF);
            if (n == 8) chk("t4_pc_wrap", 32'(imem_addr), 32'h00);
        end

        // Reset during EXEC of LDI 0x55 suppresses the write
        cycle(0, 0);
        rom_fill(8'hF0);
        rom[0] = 8'h40; rom[1] = 8'h55;
        cycle(1, 1);
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        chk("t5_in_exec", 32'(busy), 32'd1);
        cycle(0, 0);
        chk("t5_acc", 32'(acc_dbg), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        cycle(1, 0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_halted", 32'(halted), 32'd0);
        chk("t5_idle_pc", 32'(imem_addr), 32'h00);

        // Random programs with random start pulses and occasional resets
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            cycle(0, 0);
            cycle(1, 1);
            for (int c = 0; c < 300; c++)
                cycle(bit'($urandom_range(0, 255) != 0), bit'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
